// File: rtl/fir_channel_scheduler.sv
// fir_channel_scheduler: round-robin time-sharing of one fir_filter among NUM_CH sample sources,
// with a tag FIFO that routes each filter result back to its channel. Define FIR_SCHED_STATS_EN for grant_cnt.
module fir_channel_scheduler #(
    parameter int NUM_CH    = 4,
    parameter int CH_W      = 2,
    parameter int MIN_GAP   = 4,
    parameter int TAG_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    req_valid,
    input  logic [NUM_CH*8-1:0]  req_data,
    output logic [NUM_CH-1:0]    req_ready,
    output logic [7:0]           fir_x_in,
    output logic                 fir_valid_in,
    input  logic [15:0]          fir_y_out,
    input  logic                 fir_valid_out,
    output logic [15:0]          res_data,
    output logic [CH_W-1:0]      res_ch,
    output logic                 res_valid,
    output logic                 busy,
    output logic                 tag_err
`ifdef FIR_SCHED_STATS_EN
    ,
    output logic [NUM_CH*16-1:0] grant_cnt
`endif
);

    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;
    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    logic [1:0]          state_reg, state_next;
    logic [GAP_W-1:0]    gap_cnt_reg, gap_cnt_next;
    logic [CH_W-1:0]     rr_reg, rr_next;
    logic [7:0]          fir_x_in_reg;
    logic                fir_valid_in_reg;
    logic [15:0]         res_data_reg;
    logic [CH_W-1:0]     res_ch_reg;
    logic                res_valid_reg;
    logic                tag_err_reg;

    logic [CH_W-1:0]     tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]    tag_cnt_reg;
    logic                fifo_full, fifo_empty, push, pop;

    logic [7:0]          sample [NUM_CH];
    logic [2*NUM_CH-1:0] req_dbl;
    logic [NUM_CH-1:0]   req_rot;
    logic                grant_found;
    logic [CH_W:0]       grant_sum;
    logic [CH_W-1:0]     grant_ch;
    logic                issue;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_sample
            assign sample[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // Rotate requests so bit 0 is the RR pointer's channel; the lowest set bit wins.
    assign req_dbl = {req_valid, req_valid};
    assign req_rot = NUM_CH'(req_dbl >> rr_reg);

    always_comb begin
        grant_found = 1'b0;
        grant_sum   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                grant_found = 1'b1;
                grant_sum   = {1'b0, rr_reg} + (CH_W+1)'(i);
            end
        end
        if (grant_sum >= (CH_W+1)'(NUM_CH))
            grant_sum = grant_sum - (CH_W+1)'(NUM_CH);
        grant_ch = grant_sum[CH_W-1:0];
    end

    assign issue      = (state_reg == ISSUE) && grant_found;
    assign req_ready  = issue ? (NUM_CH'(1) << grant_ch) : '0;
    assign fifo_full  = (tag_cnt_reg == CNT_W'(TAG_DEPTH));
    assign fifo_empty = (tag_cnt_reg == '0);
    assign push       = issue;
    assign pop        = fir_valid_out && !fifo_empty;

    always_comb begin
        state_next   = state_reg;
        gap_cnt_next = gap_cnt_reg;
        rr_next      = rr_reg;
        case (state_reg)
            IDLE: begin
                if (|req_valid && !fifo_full)
                    state_next = ISSUE;
            end
            ISSUE: begin
                // A request withdrawn between IDLE and ISSUE just returns to IDLE.
                if (issue) begin
                    rr_next = (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + CH_W'(1);
                    if (MIN_GAP == 1) begin
                        state_next = IDLE;
                    end else begin
                        state_next   = GAP;
                        gap_cnt_next = GAP_W'(MIN_GAP - 1);
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            GAP: begin
                gap_cnt_next = gap_cnt_reg - GAP_W'(1);
                if (gap_cnt_reg <= GAP_W'(1))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            gap_cnt_reg      <= '0;
            rr_reg           <= '0;
            fir_x_in_reg     <= '0;
            fir_valid_in_reg <= 1'b0;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            tag_cnt_reg      <= '0;
            res_data_reg     <= '0;
            res_ch_reg       <= '0;
            res_valid_reg    <= 1'b0;
            tag_err_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            gap_cnt_reg      <= gap_cnt_next;
            rr_reg           <= rr_next;
            fir_valid_in_reg <= issue;
            if (issue)
                fir_x_in_reg <= sample[grant_ch];
            // Power-of-two depth lets the pointers wrap naturally.
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   tag_cnt_reg <= tag_cnt_reg + CNT_W'(1);
                2'b01:   tag_cnt_reg <= tag_cnt_reg - CNT_W'(1);
                default: ;
            endcase
            res_valid_reg <= pop;
            if (pop) begin
                res_data_reg <= fir_y_out;
                res_ch_reg   <= tag_mem[rd_ptr_reg];
            end
            if (fir_valid_out && fifo_empty)
                tag_err_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            tag_mem[wr_ptr_reg] <= grant_ch;
    end

    assign fir_x_in     = fir_x_in_reg;
    assign fir_valid_in = fir_valid_in_reg;
    assign res_data     = res_data_reg;
    assign res_ch       = res_ch_reg;
    assign res_valid    = res_valid_reg;
    assign tag_err      = tag_err_reg;
    assign busy         = !fifo_empty || (state_reg != IDLE);

`ifdef FIR_SCHED_STATS_EN
    logic [15:0] grant_cnt_reg [NUM_CH];

    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_stats
            always_ff @(posedge clk) begin
                if (rst)
                    grant_cnt_reg[gi] <= '0;
                else if (issue && grant_ch == CH_W'(gi) && grant_cnt_reg[gi] != 16'hFFFF)
                    grant_cnt_reg[gi] <= grant_cnt_reg[gi] + 16'd1;
            end
            assign grant_cnt[16*gi +: 16] = grant_cnt_reg[gi];
        end
    endgenerate
`endif

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Directed testbench for fir_channel_scheduler (NUM_CH=4, MIN_GAP=4, TAG_DEPTH=4).
module tb_fir_channel_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  fir_x_in;
    logic        fir_valid_in;
    logic [15:0] fir_y_out;
    logic        fir_valid_out;
    logic [15:0] res_data;
    logic [1:0]  res_ch;
    logic        res_valid;
    logic        busy;
    logic        tag_err;
`ifdef FIR_SCHED_STATS_EN
    logic [63:0] grant_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_cyc;
    int n;
    int pulses;
    int exp_ch;
    logic [7:0] last_x;
    logic [7:0] dat [4];

    fir_channel_scheduler #(
        .NUM_CH(4), .CH_W(2), .MIN_GAP(4), .TAG_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .fir_x_in(fir_x_in),
        .fir_valid_in(fir_valid_in),
        .fir_y_out(fir_y_out),
        .fir_valid_out(fir_valid_out),
        .res_data(res_data),
        .res_ch(res_ch),
        .res_valid(res_valid),
        .busy(busy),
        .tag_err(tag_err)
`ifdef FIR_SCHED_STATS_EN
        ,
        .grant_cnt(grant_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        dat[0] = 8'd5; dat[1] = 8'd10; dat[2] = 8'd15; dat[3] = 8'd20;
        req_data      = {dat[3], dat[2], dat[1], dat[0]};
        req_valid     = 4'b0;
        fir_y_out     = 16'h0;
        fir_valid_out = 1'b0;

        // Reset state
        rst = 1'b1;
        step(2);
        check("rst_ready", req_ready, 0);
        check("rst_valid_in", fir_valid_in, 0);
        check("rst_x_in", fir_x_in, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_ch", res_ch, 0);
        check("rst_busy", busy, 0);
        check("rst_tag_err", tag_err, 0);
        rst = 1'b0;

        // Stray result with no outstanding tags
        fir_y_out = 16'h0055; fir_valid_out = 1'b1;
        step(1);
        fir_valid_out = 1'b0;
        check("err_set", tag_err, 1);
        check("err_no_res", res_valid, 0);
        step(3);
        check("err_sticky", tag_err, 1);
        check("err_no_res_later", res_valid, 0);
        do_reset();
        check("err_cleared", tag_err, 0);

        // Single channel: ch1, x=10, y=20 three cycles after the pulse
        req_valid = 4'b0010;
        step(1);
        check("sc_ready", req_ready, 4'b0010);
        check("sc_no_pulse_yet", fir_valid_in, 0);
        step(1);
        req_valid = 4'b0;
        check("sc_pulse", fir_valid_in, 1);
        check("sc_x", fir_x_in, 10);
        check("sc_busy", busy, 1);
        step(1);
        check("sc_pulse_once", fir_valid_in, 0);
        check("sc_x_hold", fir_x_in, 10);
        step(1);
        fir_y_out = 16'd20; fir_valid_out = 1'b1;
        step(1);
        fir_valid_out = 1'b0;
        check("sc_res_valid", res_valid, 1);
        check("sc_res_ch", res_ch, 1);
        check("sc_res_data", res_data, 20);
        check("sc_idle", busy, 0);
        step(1);
        check("sc_res_strobe", res_valid, 0);

        // Round-robin: all channels valid, results returned promptly
        do_reset();
        req_valid = 4'hF;
        last_cyc = 0;
        for (int k = 0; k < 5; k++) begin
            exp_ch = k % 4;
            n = 0;
            while (req_ready === 4'b0 && n < 20) begin
                step(1);
                n++;
            end
            check("rr_wait", n < 20, 1);
            check("rr_grant", req_ready, 32'd1 << exp_ch);
            if (k > 0) check("rr_spacing", cyc - last_cyc, 5);
            last_cyc = cyc;
            step(1);
            check("rr_pulse", fir_valid_in, 1);
            check("rr_x", fir_x_in, dat[exp_ch]);
            if (k == 4) req_valid = 4'b0;
            fir_y_out = 16'h0100 + 16'(k); fir_valid_out = 1'b1;
            step(1);
            fir_valid_out = 1'b0;
            check("rr_pulse_len", fir_valid_in, 0);
            check("rr_res_valid", res_valid, 1);
            check("rr_res_ch", res_ch, exp_ch);
            check("rr_res_data", res_data, 32'h100 + k);
            $display("rr issue %0d: ch=%0d x=%0d res_ch=%0d res_data=%0h", k, exp_ch, fir_x_in, res_ch, res_data);
        end
        step(6);
        check("rr_drained", busy, 0);

        // Backpressure: withhold results; tag FIFO fills after 4 issues (order 1,2,3,0)
        req_valid = 4'hF;
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            step(1);
            if (fir_valid_in === 1'b1) pulses++;
        end
        check("bp_issues", pulses, 4);
        check("bp_ready", req_ready, 0);
        check("bp_busy", busy, 1);
        fir_y_out = 16'h0BEE; fir_valid_out = 1'b1;
        step(1);
        fir_valid_out = 1'b0;
        check("bp_rel_valid", res_valid, 1);
        check("bp_rel_ch", res_ch, 1);
        check("bp_rel_data", res_data, 16'h0BEE);
        pulses = 0;
        last_x = 8'h00;
        for (int c = 0; c < 30; c++) begin
            step(1);
            if (fir_valid_in === 1'b1) begin
                pulses++;
                last_x = fir_x_in;
            end
        end
        check("bp_one_more", pulses, 1);
        check("bp_one_more_x", last_x, dat[1]);
        check("bp_ready_again", req_ready, 0);
        check("bp_busy_again", busy, 1);
        req_valid = 4'b0;

        // Pop two of the four outstanding tags (2 and 3)
        fir_y_out = 16'h0001; fir_valid_out = 1'b1;
        step(1);
        check("pop_a_ch", res_ch, 2);
        fir_y_out = 16'h0002;
        step(1);
        fir_valid_out = 1'b0;
        check("pop_b_ch", res_ch, 3);
        check("pop_b_data", res_data, 2);
        check("pop_busy", busy, 1);

        // Reset with two tags outstanding
        rst = 1'b1;
        step(2);
        check("mr_busy", busy, 0);
        check("mr_ready", req_ready, 0);
        check("mr_valid_in", fir_valid_in, 0);
        check("mr_res_valid", res_valid, 0);
        check("mr_tag_err", tag_err, 0);
`ifdef FIR_SCHED_STATS_EN
        check("mr_grant_cnt", grant_cnt == 64'h0, 1);
`endif
        rst = 1'b0;
        fir_y_out = 16'h0077; fir_valid_out = 1'b1;
        step(1);
        fir_valid_out = 1'b0;
        check("mr_late_err", tag_err, 1);
        check("mr_late_no_res", res_valid, 0);
        check("mr_late_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
